operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Upstream feeder and result collector for the registered arithmetic datapaths (ADD/SUB/COMP/MUX2x1/SHL/SHR/REG netlists with inputs a, b, c and registered outputs x, z). It accepts a serial stream of operand words over a valid/ready port and assembles each group into an (a, b, c) triple. It holds the triple stable while the datapath computes, waits out the datapath's register latency, then captures x and z into a result buffer presented on a valid/ready output port. One triple is in flight at a time.

## Interface
- DATAWIDTH, 32, width of every operand and result word.
- LATENCY, 1, number of REG stages between a/b/c and x/z in the attached datapath; legal range 1..15.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush; discards any partial triple and any pending result.
- in_data  in  DATAWIDTH  operand word; arrival order is a, then b, then c.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- a, b, c  out  DATAWIDTH each  operands to the datapath, registered.
- x_in, z_in  in  DATAWIDTH each  registered results from the datapath.
- x_out, z_out  out  DATAWIDTH each  captured results.
- out_valid  out  1  x_out and z_out hold an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- busy  out  1  high in every state except LOAD_A.

## Operation
- States: LOAD_A, LOAD_B, LOAD_C, WAIT, RESULT.
- in_ready is 1 only in LOAD_A, LOAD_B and LOAD_C, and only when clr is 0.
- Accept condition: in_valid && in_ready.
- LOAD_A, on accept: a <= in_data, go to LOAD_B.
- LOAD_B, on accept: b <= in_data, go to LOAD_C.
- LOAD_C, on accept: c <= in_data, wcnt <= LATENCY, go to WAIT.
- With no accept, each LOAD state holds and the operand registers do not change.
- WAIT: if wcnt == 0, then x_out <= x_in, z_out <= z_in, out_valid <= 1, go to RESULT. Otherwise wcnt <= wcnt - 1.
- RESULT: out_valid stays 1 and x_out/z_out stay stable until out_ready == 1. On that handshake: out_valid <= 0, go to LOAD_A.
- a, b, c are not cleared after a result; they change only on accepted words.
- clr has priority over every handshake. At the next edge: state <= LOAD_A, out_valid <= 0, a = b = c = 0, wcnt = 0, x_out/z_out unchanged. A word or result presented in the clr cycle is not consumed.
- Rst, asynchronous: state = LOAD_A; a, b, c, x_out, z_out, wcnt = 0; out_valid = 0. in_ready is 0 while Rst is high. busy = 0.
- Arithmetic: wcnt is 4 bits, unsigned, and never wraps because it is loaded only from LATENCY. No operand arithmetic is done in this block.

## Timing
- Let T be the edge that accepts c. a/b/c are stable from T. The datapath REG chain fills by edge T+LATENCY. Capture happens at edge T+LATENCY+1, so WAIT lasts LATENCY+1 cycles.
- out_valid is high in the cycle after edge T+LATENCY+1.
- Minimum triple period with out_ready tied to 1: 3 (loads) + LATENCY+1 (wait) + 1 (result) = LATENCY+5 cycles.
- in_valid may drop between words; gaps extend the LOAD states only.
- out_ready held low stalls indefinitely in RESULT. No new words are accepted and the result is never overwritten.
- Rst asserted mid-WAIT or mid-RESULT takes effect immediately. The pending result is lost.

## Structure
- Shared package hls_pkg: the state encoding constants (3-bit: LOAD_A=0, LOAD_B=1, LOAD_C=2, WAIT=3, RESULT=4) and LAT_W=4. Other sequencers in the design reuse the same package.
- One sub-module, lat_counter: a loadable 4-bit down-counter with a zero flag, Clk/Rst per this spec. The top-level module holds the FSM and the operand/result registers.

## Test plan
All scenarios use a bench datapath model of LATENCY REG stages computing x = a+b and z = a^c.
- Reset, then feed 3, 5, 7 with out_ready = 1 -> out_valid rises exactly LATENCY+1 cycles after c is accepted; x_out = 8, z_out = 4; busy returns to 0.
- Same stimulus with LATENCY = 3 -> out_valid rises 4 cycles after c is accepted; x_out = 8, z_out = 4.
- Result 8/4 pending with out_ready = 0 for 10 cycles while in_valid = 1 -> in_ready stays 0; x_out/z_out are unchanged; after out_ready pulses, the next triple 1, 2, 3 yields x_out = 3, z_out = 2.
- Feed a = 9 and b = 4, then assert clr for one cycle; then feed 2, 2, 2 -> state restarts at LOAD_A; result x_out = 4, z_out = 0; the stale 9/4 never reaches a result.
- Assert Rst asynchronously mid-WAIT -> out_valid, a, b, c, x_out and z_out read 0 before the next Clk edge; after release, 6, 1, 6 yields x_out = 7, z_out = 0.
- Drive in_valid randomly at 30% duty over 50 triples -> every result matches the model; no word is dropped or duplicated.

Source files
------------

// File: rtl/hls_pkg.sv
// Shared definitions for the HLS-style operand sequencers: the FSM state
// encoding and the width of the latency down-counter.
package hls_pkg;

  // Width of the wait counter; LATENCY must fit in it (1..15).
  localparam int LAT_W = 4;

  // Number of operand words assembled into one triple.
  localparam int NUM_OPERANDS = 3;

  // Sequencer states. The LOAD states double as the operand slot index,
  // so their encodings must stay 0, 1, 2.
  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  // True in the states that take operand words from the input port.
  function automatic logic is_load_state(input state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_C);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with a zero flag. Counts the cycles the attached
// datapath needs before its registered outputs are valid.
module lat_counter
  import hls_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic [LAT_W-1:0] count,
  output logic             zero
);

  // Count register: flush beats load, load beats decrement; never wraps below 0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/operand_sequencer.sv
// Feeds (a, b, c) operand triples to a registered arithmetic datapath and
// collects its x/z results. Words arrive serially on a valid/ready port,
// the triple is held while the datapath computes, and the results are
// presented on a valid/ready output port. One triple in flight at a time.
module operand_sequencer
  import hls_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int LATENCY   = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] x_in,
  input  logic [DATAWIDTH-1:0] z_in,
  output logic [DATAWIDTH-1:0] x_out,
  output logic [DATAWIDTH-1:0] z_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  // Value loaded into the wait counter when c is accepted.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY);

  state_t state_reg;
  state_t state_next;

  logic [DATAWIDTH-1:0] opnd_reg [NUM_OPERANDS];
  logic [DATAWIDTH-1:0] x_reg;
  logic [DATAWIDTH-1:0] z_reg;
  logic                 out_valid_reg;

  logic             accept;
  logic             capture;
  logic             take;
  logic             wcnt_load;
  logic             wcnt_dec;
  logic             wcnt_zero;
  logic [LAT_W-1:0] wcnt;

  // Handshake qualifiers. Ready is suppressed during a flush and while the
  // asynchronous reset is held so no word is counted as taken then.
  assign in_ready  = is_load_state(state_reg) && !clr && !Rst;
  assign accept    = in_valid && in_ready;
  assign capture   = (state_reg == WAIT) && wcnt_zero && !clr;
  assign take      = (state_reg == RESULT) && out_ready && !clr;
  assign wcnt_load = accept && (state_reg == LOAD_C);
  assign wcnt_dec  = (state_reg == WAIT) && !wcnt_zero;

  // Wait counter: holds off the capture until the datapath register chain
  // has been refilled from the new operands.
  lat_counter u_lat_counter (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr      (clr),
    .load     (wcnt_load),
    .load_val (LAT_LOAD),
    .dec      (wcnt_dec),
    .count    (wcnt),
    .zero     (wcnt_zero)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= LOAD_A;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a flush overrides every handshake.
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = LOAD_A;
    end else begin
      case (state_reg)
        LOAD_A:  if (accept)    state_next = LOAD_B;
        LOAD_B:  if (accept)    state_next = LOAD_C;
        LOAD_C:  if (accept)    state_next = WAIT;
        WAIT:    if (wcnt_zero) state_next = RESULT;
        RESULT:  if (out_ready) state_next = LOAD_A;
        default:                state_next = LOAD_A;
      endcase
    end
  end

  // Operand slots: slot gi is written only by a word accepted in the LOAD
  // state whose encoding equals gi, and otherwise holds across results.
  for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_opnd
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        opnd_reg[gi] <= '0;
      end else if (clr) begin
        opnd_reg[gi] <= '0;
      end else if (accept && (state_reg == state_t'(gi))) begin
        opnd_reg[gi] <= in_data;
      end
    end
  end

  assign a = opnd_reg[0];
  assign b = opnd_reg[1];
  assign c = opnd_reg[2];

  // Result buffer: captured once per triple and left untouched by a flush,
  // so a stalled consumer always sees the same values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x_reg <= '0;
      z_reg <= '0;
    end else if (capture) begin
      x_reg <= x_in;
      z_reg <= z_in;
    end
  end

  // Output valid flag: set on capture, cleared on consumption or flush.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
    end else if (capture) begin
      out_valid_reg <= 1'b1;
    end else if (take) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign x_out     = x_reg;
  assign z_out     = z_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != LOAD_A);

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer. Two instances (LATENCY 1 and 3)
// each drive a model datapath computing x = a+b and z = a^c through LATENCY
// register stages. Expected results are queued as triples are sent and
// popped when the sequencer presents a result.
module tb_operand_sequencer;

  logic        Clk;
  logic        Rst;

  // LATENCY = 1 instance
  logic        clr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, c;
  logic [31:0] x_in, z_in;
  logic [31:0] x_out, z_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  // LATENCY = 3 instance
  logic        l3_clr;
  logic [31:0] l3_in_data;
  logic        l3_in_valid;
  logic        l3_in_ready;
  logic [31:0] l3_a, l3_b, l3_c;
  logic [31:0] l3_x_in, l3_z_in;
  logic [31:0] l3_x_out, l3_z_out;
  logic        l3_out_valid;
  logic        l3_out_ready;
  logic        l3_busy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q [$];

  operand_sequencer #(.DATAWIDTH(32), .LATENCY(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c),
    .x_in(x_in), .z_in(z_in),
    .x_out(x_out), .z_out(z_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  operand_sequencer #(.DATAWIDTH(32), .LATENCY(3)) u_dut_l3 (
    .Clk(Clk), .Rst(Rst), .clr(l3_clr),
    .in_data(l3_in_data), .in_valid(l3_in_valid), .in_ready(l3_in_ready),
    .a(l3_a), .b(l3_b), .c(l3_c),
    .x_in(l3_x_in), .z_in(l3_z_in),
    .x_out(l3_x_out), .z_out(l3_z_out),
    .out_valid(l3_out_valid), .out_ready(l3_out_ready), .busy(l3_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Datapath model, one register stage.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x_in <= '0;
      z_in <= '0;
    end else begin
      x_in <= a + b;
      z_in <= a ^ c;
    end
  end

  // Datapath model, three register stages.
  logic [31:0] l3_xp [3];
  logic [31:0] l3_zp [3];
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 3; i++) begin
        l3_xp[i] <= '0;
        l3_zp[i] <= '0;
      end
    end else begin
      l3_xp[0] <= l3_a + l3_b;
      l3_zp[0] <= l3_a ^ l3_c;
      l3_xp[1] <= l3_xp[0];
      l3_zp[1] <= l3_zp[0];
      l3_xp[2] <= l3_xp[1];
      l3_zp[2] <= l3_zp[1];
    end
  end
  assign l3_x_in = l3_xp[2];
  assign l3_z_in = l3_zp[2];

  // Offer one word to the LATENCY=1 instance; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d);
    int n;
    @(negedge Clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_word: in_ready=%0b required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge Clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_triple(input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] cv, input bit push);
    if (push) exp_q.push_back({av + bv, av ^ cv});
    send_word(av);
    send_word(bv);
    send_word(cv);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%0b out_valid=%0b required 0 0", busy, out_valid);
    end
    checks++;
    if ({a, b, c, x_out, z_out} !== '0) begin
      errors++; $display("FAIL reset_regs: a=%h b=%h c=%h x=%h z=%h required all 0", a, b, c, x_out, z_out);
    end
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    int lat;
    logic [63:0] e;
    out_ready = 1'b1;
    send_triple(32'd3, 32'd5, 32'd7, 1'b1);
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL basic_latency: got %0d cycles required 2", lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL basic_queue: got empty required 1 entry");
    end else begin
      e = exp_q.pop_front();
      if ({x_out, z_out} !== e) begin
        errors++; $display("FAIL basic_result: got x=%0d z=%0d required x=%0d z=%0d", x_out, z_out, e[63:32], e[31:0]);
      end
    end
    $display("basic result x=%0d z=%0d latency=%0d", x_out, z_out, lat);
    @(posedge Clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle: busy=%0b out_valid=%0b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_latency3();
    int lat;
    int n;
    logic [31:0] words [3];
    logic [63:0] e;
    words = '{32'd3, 32'd5, 32'd7};
    l3_out_ready = 1'b1;
    exp_q.push_back({words[0] + words[1], words[0] ^ words[2]});
    for (int w = 0; w < 3; w++) begin
      @(negedge Clk);
      l3_in_valid = 1'b1;
      l3_in_data  = words[w];
      n = 0;
      while (!l3_in_ready && n < 50) begin
        @(negedge Clk);
        n++;
      end
      @(posedge Clk);
      #1 l3_in_valid = 1'b0;
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
      if (l3_out_valid) break;
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL lat3_latency: got %0d cycles required 4", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({l3_x_out, l3_z_out} !== e) begin
      errors++; $display("FAIL lat3_result: got x=%0d z=%0d required x=%0d z=%0d", l3_x_out, l3_z_out, e[63:32], e[31:0]);
    end
    $display("latency3 result x=%0d z=%0d latency=%0d", l3_x_out, l3_z_out, lat);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_stall();
    int n;
    logic [63:0] e;
    out_ready = 1'b0;
    send_triple(32'd3, 32'd5, 32'd7, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++; $display("FAIL stall_wait: out_valid=%0b required 1", out_valid);
    end
    @(negedge Clk);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if ({in_ready, out_valid, x_out, z_out} !== {1'b0, 1'b1, 32'd8, 32'd4}) begin
        errors++; $display("FAIL stall_hold: cycle %0d in_ready=%0b out_valid=%0b x=%0d z=%0d required 0 1 8 4",
                           i, in_ready, out_valid, x_out, z_out);
      end
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({x_out, z_out} !== e) begin
      errors++; $display("FAIL stall_result: got x=%0d z=%0d required x=%0d z=%0d", x_out, z_out, e[63:32], e[31:0]);
    end
    $display("stalled result x=%0d z=%0d", x_out, z_out);
    out_ready = 1'b1;
    send_triple(32'd1, 32'd2, 32'd3, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!out_valid || {x_out, z_out} !== e) begin
      errors++; $display("FAIL stall_next: out_valid=%0b x=%0d z=%0d required 1 x=%0d z=%0d",
                         out_valid, x_out, z_out, e[63:32], e[31:0]);
    end
    $display("post-stall result x=%0d z=%0d", x_out, z_out);
  endtask

  task automatic test_clr();
    int n;
    logic [63:0] e;
    out_ready = 1'b1;
    send_word(32'd9);
    send_word(32'd4);
    @(negedge Clk);
    in_valid = 1'b1;
    in_data  = 32'd77;
    clr      = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL clr_ready: in_ready=%0b required 0", in_ready);
    end
    @(negedge Clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({busy, a, b, c} !== '0) begin
      errors++; $display("FAIL clr_flush: busy=%0b a=%0d b=%0d c=%0d required 0 0 0 0", busy, a, b, c);
    end
    send_triple(32'd2, 32'd2, 32'd2, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!out_valid || {x_out, z_out} !== e) begin
      errors++; $display("FAIL clr_result: out_valid=%0b x=%0d z=%0d required 1 x=%0d z=%0d",
                         out_valid, x_out, z_out, e[63:32], e[31:0]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL clr_queue: %0d entries left required 0", exp_q.size());
    end
    $display("post-clr result x=%0d z=%0d", x_out, z_out);
  endtask

  task automatic test_rst_mid_wait();
    int n;
    logic [63:0] e;
    out_ready = 1'b1;
    send_triple(32'd10, 32'd20, 32'd30, 1'b0);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, a, b, c, x_out, z_out} !== '0) begin
      errors++; $display("FAIL rst_async: out_valid=%0b busy=%0b in_ready=%0b a=%0d b=%0d c=%0d x=%0d z=%0d required all 0",
                         out_valid, busy, in_ready, a, b, c, x_out, z_out);
    end
    @(negedge Clk);
    Rst = 1'b0;
    send_triple(32'd6, 32'd1, 32'd6, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!out_valid || {x_out, z_out} !== e) begin
      errors++; $display("FAIL rst_result: out_valid=%0b x=%0d z=%0d required 1 x=%0d z=%0d",
                         out_valid, x_out, z_out, e[63:32], e[31:0]);
    end
    $display("post-reset result x=%0d z=%0d", x_out, z_out);
  endtask

  task automatic test_random();
    int received;
    out_ready = 1'b1;
    received  = 0;
    fork
      begin : driver
        logic [31:0] w [3];
        bit done;
        int n;
        for (int t = 0; t < 50; t++) begin
          w[0] = $urandom;
          w[1] = $urandom;
          w[2] = $urandom;
          exp_q.push_back({w[0] + w[1], w[0] ^ w[2]});
          for (int k = 0; k < 3; k++) begin
            done = 1'b0;
            n = 0;
            while (!done && n < 2000) begin
              @(negedge Clk);
              n++;
              in_valid = ($urandom_range(0, 99) < 30);
              in_data  = in_valid ? w[k] : $urandom;
              if (in_valid && in_ready) begin
                @(posedge Clk);
                #1 in_valid = 1'b0;
                done = 1'b1;
              end
            end
          end
        end
        in_valid = 1'b0;
      end
      begin : collector
        logic [63:0] e;
        int cyc;
        cyc = 0;
        while (received < 50 && cyc < 20000) begin
          @(negedge Clk);
          cyc++;
          if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL random_extra: result x=%h z=%h with no expected entry", x_out, z_out);
            end else begin
              e = exp_q.pop_front();
              if ({x_out, z_out} !== e) begin
                errors++; $display("FAIL random_result %0d: got x=%h z=%h required x=%h z=%h",
                                   received, x_out, z_out, e[63:32], e[31:0]);
              end
            end
            $display("random result %0d x=%h z=%h", received, x_out, z_out);
            received++;
          end
        end
      end
    join
    checks++;
    if (received != 50 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_count: got %0d results with %0d pending required 50 with 0 pending",
                         received, exp_q.size());
    end
  endtask

  initial begin
    Rst          = 1'b1;
    clr          = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    l3_clr       = 1'b0;
    l3_in_data   = '0;
    l3_in_valid  = 1'b0;
    l3_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_latency3();
    test_stall();
    test_clr();
    test_rst_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
